// File: rtl/latch_mem_pkg.sv
// latch_mem_pkg: shared state encoding and sizing helpers for the latch memory controller
package latch_mem_pkg;
    typedef enum logic [1:0] {
        ST_SETUP  = 2'b00,
        ST_ACCESS = 2'b01,
        ST_HOLD   = 2'b10,
        ST_IDLE   = 2'b11
    } state_e;

    function automatic int cnt_width(input int acc);
        return (acc > 2) ? $clog2(acc) : 1;
    endfunction
endpackage

// File: rtl/latch_mem_ctrl_if.sv
// latch_mem_ctrl_if: 4-phase select/valid request bus between requester and controller
interface latch_mem_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              select;
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              valid;
    logic              rw;
    logic [WIDTH-1:0]  rdata;
    logic              err;
    logic              busy;
    logic [1:0]        state;

    modport master (output select, op, addr, wdata, input valid, rw, rdata, err, busy, state);
    modport slave  (input select, op, addr, wdata, output valid, rw, rdata, err, busy, state);
endinterface

// File: rtl/latch_word_array.sv
// latch_word_array: DEPTH x WIDTH storage with async clear, one write port and a combinational read port
module latch_word_array #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Clear every word on reset; otherwise commit the addressed word when enabled and in range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i && ({1'b0, waddr_i} < DEPTH_L)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = ({1'b0, raddr_i} < DEPTH_L) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/latch_mem_ctrl.sv
// latch_mem_ctrl: handshake FSM, access-window counter and capture registers in front of the latch array
module latch_mem_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int ACC_CYCLES = 2
) (
    input logic             clk,
    input logic             rst_n,
    latch_mem_ctrl_if.slave bus
);
    import latch_mem_pkg::*;

    localparam int              CW       = cnt_width(ACC_CYCLES);
    localparam logic [CW-1:0]   CNT_INIT = CW'(ACC_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic [WIDTH-1:0]  arr_rdata;
    logic              last;

    assign last = (state_q == ST_ACCESS) && (cnt_q == '0);

    latch_word_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_arr (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (last && op_q && !err_q),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (addr_q),
        .rdata_o (arr_rdata)
    );

    // Next-state logic: request capture in IDLE, range check in SETUP, commit on the last ACCESS cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: if (bus.select) begin
                state_d = ST_SETUP;
                op_d    = bus.op;
                addr_d  = bus.addr;
                wdata_d = bus.wdata;
                err_d   = 1'b0;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_INIT;
                err_d   = {1'b0, addr_q} >= DEPTH_L;
            end
            ST_ACCESS: if (cnt_q == '0) begin
                state_d = ST_HOLD;
                rdata_d = op_q ? rdata_q : (err_q ? '0 : arr_rdata);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            ST_HOLD: state_d = bus.select ? ST_HOLD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers; async reset drops any uncommitted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.valid = state_q == ST_HOLD;
    assign bus.busy  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.rw    = op_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_latch_mem_ctrl.sv
// tb_latch_mem_ctrl: directed tests of the latch memory controller across three parameter sets
module tb_latch_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    latch_mem_ctrl_if #(.WIDTH(8),  .ADDR_W(4)) m0();
    latch_mem_ctrl_if #(.WIDTH(16), .ADDR_W(4)) m1();
    latch_mem_ctrl_if #(.WIDTH(1),  .ADDR_W(1)) m2();

    latch_mem_ctrl #(.WIDTH(8),  .DEPTH(12), .ADDR_W(4), .ACC_CYCLES(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(m0));
    latch_mem_ctrl #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .ACC_CYCLES(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(m1));
    latch_mem_ctrl #(.WIDTH(1),  .DEPTH(2),  .ADDR_W(1), .ACC_CYCLES(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(m2));

    task automatic txn0(input logic o, input logic [3:0] a, input logic [7:0] d, output int lat);
        m0.select = 1'b1; m0.op = o; m0.addr = a; m0.wdata = d;
        @(posedge clk); lat = 0;
        @(negedge clk);
        while (!m0.valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        if (!m0.valid) lat = 99;
    endtask

    task automatic drop0();
        m0.select = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic txn1(input logic o, input logic [3:0] a, input logic [15:0] d, output int lat);
        m1.select = 1'b1; m1.op = o; m1.addr = a; m1.wdata = d;
        @(posedge clk); lat = 0;
        @(negedge clk);
        while (!m1.valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        if (!m1.valid) lat = 99;
        m1.select = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic txn2(input logic o, input logic a, input logic d, output int lat);
        m2.select = 1'b1; m2.op = o; m2.addr = a; m2.wdata = d;
        @(posedge clk); lat = 0;
        @(negedge clk);
        while (!m2.valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        if (!m2.valid) lat = 99;
        m2.select = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0.select = 1'b0; m0.op = 1'b1; m0.addr = '0; m0.wdata = '0;
        m1.select = 1'b0; m1.op = 1'b0; m1.addr = '0; m1.wdata = '0;
        m2.select = 1'b0; m2.op = 1'b0; m2.addr = '0; m2.wdata = '0;
        repeat (2) @(negedge clk);
        total++; if (m0.state !== 2'b11 || m0.valid !== 1'b0 || m0.busy !== 1'b0 || m0.rdata !== 8'h00 || m0.err !== 1'b0 || m0.rw !== 1'b0)
            $display("FAIL reset_hold: state=%b valid=%b busy=%b rdata=%h err=%b rw=%b expected 11 0 0 00 0 0", m0.state, m0.valid, m0.busy, m0.rdata, m0.err, m0.rw);
        else passed++;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            total++; if (m0.state !== 2'b11 || m0.valid !== 1'b0 || m0.busy !== 1'b0 || m0.rdata !== 8'h00)
                $display("FAIL idle_op_only[%0d]: state=%b valid=%b busy=%b rdata=%h expected 11 0 0 00", k, m0.state, m0.valid, m0.busy, m0.rdata);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        logic [1:0] exp_st [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        logic       exp_bz [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int lat;
        m0.select = 1'b1; m0.op = 1'b1; m0.addr = 4'd3; m0.wdata = 8'hA5;
        total++; if (m0.state !== 2'b11) $display("FAIL wr_pre_state: got %b expected 11", m0.state); else passed++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            total++; if (m0.state !== exp_st[k] || m0.busy !== exp_bz[k] || m0.valid !== (k == 3))
                $display("FAIL wr_seq[%0d]: state=%b busy=%b valid=%b expected %b %b %b", k, m0.state, m0.busy, m0.valid, exp_st[k], exp_bz[k], k == 3);
            else passed++;
        end
        total++; if (m0.rw !== 1'b1 || m0.err !== 1'b0) $display("FAIL wr_rw: rw=%b err=%b expected 1 0", m0.rw, m0.err); else passed++;
        drop0();
        total++; if (m0.state !== 2'b11 || m0.valid !== 1'b0) $display("FAIL wr_drop: state=%b valid=%b expected 11 0", m0.state, m0.valid); else passed++;
        txn0(1'b0, 4'd3, 8'h00, lat);
        total++; if (lat !== 3) $display("FAIL rd_latency: got %0d expected 3", lat); else passed++;
        total++; if (m0.rdata !== 8'hA5 || m0.rw !== 1'b0 || m0.err !== 1'b0)
            $display("FAIL rd_data: rdata=%h rw=%b err=%b expected a5 0 0", m0.rdata, m0.rw, m0.err);
        else passed++;
        drop0();
    endtask

    task automatic test_out_of_range();
        int lat;
        txn0(1'b1, 4'd13, 8'hFF, lat);
        total++; if (m0.err !== 1'b1 || m0.valid !== 1'b1 || m0.rdata !== 8'hA5)
            $display("FAIL oor_write: err=%b valid=%b rdata=%h expected 1 1 a5", m0.err, m0.valid, m0.rdata);
        else passed++;
        drop0();
        txn0(1'b0, 4'd13, 8'h00, lat);
        total++; if (m0.err !== 1'b1 || m0.rdata !== 8'h00) $display("FAIL oor_read13: err=%b rdata=%h expected 1 00", m0.err, m0.rdata); else passed++;
        drop0();
        txn0(1'b0, 4'd12, 8'h00, lat);
        total++; if (m0.err !== 1'b1) $display("FAIL oor_read12: err=%b expected 1", m0.err); else passed++;
        drop0();
        txn0(1'b0, 4'd11, 8'h00, lat);
        total++; if (m0.err !== 1'b0 || m0.rdata !== 8'h00) $display("FAIL oor_read11: err=%b rdata=%h expected 0 00", m0.err, m0.rdata); else passed++;
        drop0();
    endtask

    task automatic test_handshake_hold();
        int lat;
        txn0(1'b1, 4'd1, 8'h5A, lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            total++; if (m0.state !== 2'b10 || m0.valid !== 1'b1)
                $display("FAIL hold[%0d]: state=%b valid=%b expected 10 1", k, m0.state, m0.valid);
            else passed++;
        end
        drop0();
        total++; if (m0.state !== 2'b11 || m0.valid !== 1'b0) $display("FAIL hold_release: state=%b valid=%b expected 11 0", m0.state, m0.valid); else passed++;
        m0.select = 1'b1; m0.op = 1'b0; m0.addr = 4'd1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        m0.select = 1'b0;
        lat = 0;
        while (!m0.valid && lat < 10) begin @(posedge clk); lat++; @(negedge clk); end
        total++; if (m0.valid !== 1'b1 || m0.rdata !== 8'h5A)
            $display("FAIL access_drop: valid=%b rdata=%h expected 1 5a", m0.valid, m0.rdata);
        else passed++;
        @(posedge clk); @(negedge clk);
        total++; if (m0.state !== 2'b11) $display("FAIL access_drop_idle: state=%b expected 11", m0.state); else passed++;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        m0.select = 1'b1; m0.op = 1'b1; m0.addr = 4'd5; m0.wdata = 8'h3C;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        total++; if (m0.state !== 2'b01) $display("FAIL mid_pre_state: got %b expected 01", m0.state); else passed++;
        rst_n = 1'b0;
        m0.select = 1'b0;
        #1;
        total++; if (m0.state !== 2'b11 || m0.valid !== 1'b0 || m0.busy !== 1'b0 || m0.rdata !== 8'h00 || m0.rw !== 1'b0)
            $display("FAIL mid_reset: state=%b valid=%b busy=%b rdata=%h rw=%b expected 11 0 0 00 0", m0.state, m0.valid, m0.busy, m0.rdata, m0.rw);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn0(1'b0, 4'd5, 8'h00, lat);
        total++; if (m0.rdata !== 8'h00 || m0.err !== 1'b0) $display("FAIL mid_read5: rdata=%h err=%b expected 00 0", m0.rdata, m0.err); else passed++;
        drop0();
        txn0(1'b0, 4'd3, 8'h00, lat);
        total++; if (m0.rdata !== 8'h00) $display("FAIL mid_read3_cleared: rdata=%h expected 00", m0.rdata); else passed++;
        drop0();
    endtask

    task automatic test_sweep_wide();
        int lat;
        logic [15:0] exp;
        for (int a = 0; a < 16; a++) begin
            exp = 16'h0001 << a;
            txn1(1'b1, 4'(a), exp, lat);
            total++; if (lat !== 5) $display("FAIL wide_wr_lat[%0d]: got %0d expected 5", a, lat); else passed++;
        end
        for (int a = 0; a < 16; a++) begin
            exp = 16'h0001 << a;
            txn1(1'b0, 4'(a), 16'h0000, lat);
            total++; if (m1.rdata !== exp || m1.err !== 1'b0)
                $display("FAIL wide_rd[%0d]: rdata=%h err=%b expected %h 0", a, m1.rdata, m1.err, exp);
            else passed++;
        end
    endtask

    task automatic test_sweep_narrow();
        int lat;
        txn2(1'b1, 1'b0, 1'b1, lat);
        total++; if (lat !== 2) $display("FAIL narrow_lat: got %0d expected 2", lat); else passed++;
        txn2(1'b0, 1'b0, 1'b0, lat);
        total++; if (m2.rdata !== 1'b1) $display("FAIL narrow_rd0: got %b expected 1", m2.rdata); else passed++;
        txn2(1'b0, 1'b1, 1'b0, lat);
        total++; if (m2.rdata !== 1'b0) $display("FAIL narrow_rd1_clear: got %b expected 0", m2.rdata); else passed++;
        txn2(1'b1, 1'b1, 1'b1, lat);
        txn2(1'b1, 1'b0, 1'b0, lat);
        txn2(1'b0, 1'b1, 1'b0, lat);
        total++; if (m2.rdata !== 1'b1 || m2.err !== 1'b0) $display("FAIL narrow_rd1: rdata=%b err=%b expected 1 0", m2.rdata, m2.err); else passed++;
        txn2(1'b0, 1'b0, 1'b0, lat);
        total++; if (m2.rdata !== 1'b0) $display("FAIL narrow_rd0_after: got %b expected 0", m2.rdata); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_handshake_hold();
        test_reset_mid_op();
        test_sweep_wide();
        test_sweep_narrow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
